shared_pin_arb: RTL



---
 rtl/shared_pin_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/shared_pin_arb.sv
// Shares the SCL/LED and SDA/button pads between idle LED/button use and an I2C master.
// Ownership changes only after both pads have been released for GUARD cycles.
module shared_pin_arb #(
  parameter int GUARD      = 16,
  parameter int SAMPLE_DIV = 256,
  parameter int DEBOUNCE   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic led,
  input  logic i2c_req,
  output logic i2c_gnt,
  input  logic i2c_scl_oe,
  input  logic i2c_sda_oe,
  output logic i2c_sda_i,
  output logic pad_scl_oe,
  output logic pad_scl_o,
  output logic pad_sda_oe,
  output logic pad_sda_o,
  input  logic pad_sda_i,
  output logic btn,
  output logic btn_rise,
  output logic btn_fall
);

  localparam int SW = $clog2(SAMPLE_DIV);
  localparam int GW = $clog2(GUARD + 1);

  typedef enum logic [1:0] {ST_LED, ST_PRE, ST_GRANT, ST_POST} state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] guard_reg, guard_next;
  logic [SW-1:0] sample_reg;
  logic [3:0]    deb_reg;
  logic          strobe;
  logic          sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_LED;
      guard_reg <= '0;
    end else begin
      state_reg <= state_next;
      guard_reg <= guard_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    guard_next = guard_reg;
    i2c_gnt    = 1'b0;
    pad_scl_oe = 1'b0;
    pad_scl_o  = 1'b0;
    pad_sda_oe = 1'b0;
    pad_sda_o  = 1'b0;
    i2c_sda_i  = pad_sda_i;
    case (state_reg)
      ST_LED: begin
        pad_scl_oe = 1'b1;
        pad_scl_o  = led;
        if (i2c_req) begin
          state_next = ST_PRE;
          guard_next = '0;
        end
      end
      ST_PRE: begin
        // A request withdrawn during the guard window never sees a grant.
        if (!i2c_req) begin
          state_next = ST_LED;
        end else if (guard_reg == GW'(GUARD - 1)) begin
          state_next = ST_GRANT;
        end else begin
          guard_next = guard_reg + GW'(1);
        end
      end
      ST_GRANT: begin
        i2c_gnt    = 1'b1;
        pad_scl_oe = i2c_scl_oe;
        pad_sda_oe = i2c_sda_oe;
        if (!i2c_req) begin
          state_next = ST_POST;
          guard_next = '0;
        end
      end
      default: begin
        if (guard_reg == GW'(GUARD - 1)) begin
          state_next = ST_LED;
        end else begin
          guard_next = guard_reg + GW'(1);
        end
      end
    endcase
  end

  // Sample strobe fires when the free-running divider wraps.
  assign strobe = &sample_reg;
  assign sample = ~pad_sda_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_reg <= '0;
      deb_reg    <= '0;
      btn        <= 1'b0;
      btn_rise   <= 1'b0;
      btn_fall   <= 1'b0;
    end else begin
      sample_reg <= sample_reg + SW'(1);
      btn_rise   <= 1'b0;
      btn_fall   <= 1'b0;
      // Outside LED mode the pad carries SDA, so the debounce count is frozen.
      if (strobe && state_reg == ST_LED) begin
        if (sample == btn) begin
          deb_reg <= '0;
        end else if (deb_reg == 4'(DEBOUNCE - 1)) begin
          btn      <= sample;
          deb_reg  <= '0;
          btn_rise <= sample;
          btn_fall <= ~sample;
        end else begin
          deb_reg <= deb_reg + 4'd1;
        end
      end
    end
  end

endmodule
